// File: rtl/load_unit_if.sv
// load_unit_if: native memory read bus between the load unit and memory.
interface load_unit_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master(output mem_valid, mem_addr, input mem_ready, mem_rdata);
  modport slave(input mem_valid, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/load_unit.sv
// load_unit: single-request load engine with alignment checks, lane extraction and bus timeout.
module load_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        fault,
  output logic [1:0]  fault_cause,
  load_unit_if.master mem
);
  typedef enum logic [1:0] {IDLE, CHECK, REQ, RESP} state_t;
  state_t      state, state_n;
  logic [2:0]  f3;
  logic [1:0]  lo;
  logic [15:0] cnt;
  logic        illegal, misaligned, timeout;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ext;
  assign busy          = state != IDLE;
  assign done          = state == RESP;
  assign fault         = |fault_cause;
  assign mem.mem_valid = state == REQ;
  always_comb begin
    illegal    = (f3[1] & f3[0]) | (f3[2] & f3[1]);
    misaligned = f3[0] ? lo[0] : f3[1] & |lo;
    timeout    = !mem.mem_ready && cnt == 16'(TIMEOUT - 1);
    b   = lo[1] ? (lo[0] ? mem.mem_rdata[31:24] : mem.mem_rdata[23:16])
                : (lo[0] ? mem.mem_rdata[15:8]  : mem.mem_rdata[7:0]);
    h   = lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    ext = f3[1] ? mem.mem_rdata
        : f3[0] ? {{16{h[15] & ~f3[2]}}, h} : {{24{b[7] & ~f3[2]}}, b};
    state_n = state == IDLE  ? (start ? CHECK : IDLE)
            : state == CHECK ? (illegal | misaligned ? RESP : REQ)
            : state == REQ   ? (mem.mem_ready | timeout ? RESP : REQ)
            : IDLE;
  end
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  always_ff @(posedge clk)
    if (!resetn) begin
      f3           <= '0;
      lo           <= '0;
      cnt          <= '0;
      result       <= '0;
      fault_cause  <= '0;
      mem.mem_addr <= '0;
    end else if (state == IDLE && start) begin
      f3           <= funct3;
      lo           <= addr[1:0];
      mem.mem_addr <= {addr[31:2], 2'b00};
      result       <= '0;
      fault_cause  <= '0;
    end else if (state == CHECK) begin
      cnt         <= '0;
      fault_cause <= illegal ? 2'b10 : misaligned ? 2'b01 : 2'b00;
    end else if (state == REQ) begin
      cnt <= cnt + 16'd1;
      if (mem.mem_ready) result <= ext;
      else if (timeout)  fault_cause <= 2'b11;
    end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed load sequence with an expected-result scoreboard on two load_unit instances.
module tb_load_unit;
  logic        clk = 0, resetn = 0, start_a = 0, start_b = 0, sel = 0, rdy = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0, rdata = 0;
  logic        busy_a, done_a, fault_a, busy_b, done_b, fault_b;
  logic [31:0] result_a, result_b;
  logic [1:0]  cause_a, cause_b;
  logic        o_busy, o_done, o_fault, o_valid;
  logic [31:0] o_result, o_addr;
  logic [1:0]  o_cause;
  int          n_cmp = 0, n_err = 0;
  logic [33:0] exp_q[$];
  load_unit_if mif_a();
  load_unit_if mif_b();
  always #5 clk = ~clk;
  assign mif_a.mem_ready = !sel & rdy;
  assign mif_b.mem_ready = sel & rdy;
  assign mif_a.mem_rdata = rdata;
  assign mif_b.mem_rdata = rdata;
  assign o_busy   = sel ? busy_b : busy_a;
  assign o_done   = sel ? done_b : done_a;
  assign o_fault  = sel ? fault_b : fault_a;
  assign o_result = sel ? result_b : result_a;
  assign o_cause  = sel ? cause_b : cause_a;
  assign o_valid  = sel ? mif_b.mem_valid : mif_a.mem_valid;
  assign o_addr   = sel ? mif_b.mem_addr : mif_a.mem_addr;
  load_unit dut_a (.clk(clk), .resetn(resetn), .start(start_a), .funct3(funct3), .addr(addr),
    .busy(busy_a), .done(done_a), .result(result_a), .fault(fault_a), .fault_cause(cause_a), .mem(mif_a.master));
  load_unit #(.TIMEOUT(4)) dut_b (.clk(clk), .resetn(resetn), .start(start_b), .funct3(funct3), .addr(addr),
    .busy(busy_b), .done(done_b), .result(result_b), .fault(fault_b), .fault_cause(cause_b), .mem(mif_b.master));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask
  function automatic logic [33:0] model(input logic [2:0] f, input logic [31:0] ad, input logic [31:0] rd, input bit to);
    logic [7:0]  bb;
    logic [15:0] hh;
    logic [1:0]  c;
    logic [31:0] r;
    bb = rd[8 * ad[1:0] +: 8];
    hh = rd[16 * ad[1] +: 16];
    c  = 2'b00;
    r  = '0;
    case (f)
      3'b000: r = {{24{bb[7]}}, bb};
      3'b100: r = {24'h0, bb};
      3'b001: if (ad[0]) c = 2'b01; else r = {{16{hh[15]}}, hh};
      3'b101: if (ad[0]) c = 2'b01; else r = {16'h0, hh};
      3'b010: if (ad[1:0] != 2'b00) c = 2'b01; else r = rd;
      default: c = 2'b10;
    endcase
    if (c != 2'b00) r = '0;
    else if (to) begin
      c = 2'b11;
      r = '0;
    end
    return {c, r};
  endfunction
  // Ready is raised in the (dly+1)-th mem_valid cycle; a dly at or beyond TIMEOUT means a timeout.
  task automatic do_load(input bit s, input logic [2:0] f, input logic [31:0] ad, input logic [31:0] rd,
                         input int dly, input bit spam);
    int t, cyc, nv, lat, nvx;
    bit got, bad_addr, flt;
    logic [33:0] e, m;
    logic [31:0] a0;
    t = s ? 4 : 255;
    sel = s;
    funct3 = f;
    addr = ad;
    rdata = rd;
    m = model(f, ad, rd, dly >= t);
    exp_q.push_back(m);
    flt = m[33:32] inside {2'b01, 2'b10};
    lat = flt ? 2 : m[33:32] == 2'b11 ? 2 + t : 3 + dly;
    nvx = flt ? 0 : m[33:32] == 2'b11 ? t : dly + 1;
    if (s) start_b = 1; else start_a = 1;
    step;
    start_a = 0;
    start_b = 0;
    cyc = 1; nv = 0; got = 0; bad_addr = 0; a0 = '0;
    while (!got && cyc < 400) begin
      if (spam) begin
        start_a = !s;
        start_b = s;
        funct3 = 3'b010;
        addr = 32'h0000_7770;
      end
      if (o_valid) begin
        nv++;
        if (nv == 1) a0 = o_addr;
        else if (o_addr !== a0) bad_addr = 1;
      end
      rdy = o_valid && nv == dly + 1;
      if (o_done) begin
        got = 1;
        e = exp_q.pop_front();
        chk("result", o_result, e[31:0]);
        chk("fault", 32'(o_fault), 32'(|e[33:32]));
        chk("fault_cause", 32'(o_cause), 32'(e[33:32]));
        chk("latency", cyc, lat);
      end else begin
        step;
        cyc++;
      end
    end
    chk("done_seen", 32'(got), 1);
    chk("valid_cycles", nv, nvx);
    if (nv > 0) begin
      chk("mem_addr", a0, {ad[31:2], 2'b00});
      chk("addr_stable", 32'(bad_addr), 0);
    end
    start_a = 0;
    start_b = 0;
    rdy = 0;
    step;
    chk("busy_after", 32'(o_busy), 0);
    chk("done_after", 32'(o_done), 0);
  endtask
  initial begin
    int nd;
    step;
    step;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_result", result_a, 0);
    chk("rst_fault", 32'(fault_a), 0);
    chk("rst_cause", 32'(cause_a), 0);
    chk("rst_valid", 32'(mif_a.mem_valid), 0);
    chk("rst_addr", mif_a.mem_addr, 0);
    chk("rst_valid_b", 32'(mif_b.mem_valid), 0);
    resetn = 1;
    step;
    do_load(0, 3'b000, 32'h0000_1003, 32'h80FF_0011, 0, 0);
    do_load(0, 3'b100, 32'h0000_2002, 32'h8765_4321, 0, 0);
    do_load(0, 3'b101, 32'h0000_2002, 32'h8765_4321, 0, 0);
    do_load(0, 3'b001, 32'h0000_2002, 32'h8765_4321, 0, 0);
    do_load(0, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 5, 1);
    do_load(0, 3'b010, 32'h0000_3002, 32'h1111_1111, 0, 0);
    do_load(0, 3'b001, 32'h0000_3001, 32'h1111_1111, 0, 0);
    do_load(0, 3'b011, 32'h0000_3000, 32'h1111_1111, 0, 0);
    do_load(0, 3'b110, 32'h0000_3000, 32'h1111_1111, 0, 0);
    do_load(0, 3'b111, 32'h0000_3004, 32'h1111_1111, 0, 0);
    do_load(0, 3'b000, 32'h0000_4001, 32'h0000_7F00, 2, 0);
    do_load(0, 3'b100, 32'h0000_4000, 32'h0000_00F3, 1, 0);
    do_load(0, 3'b001, 32'h0000_4000, 32'hFFFF_8001, 0, 0);
    do_load(0, 3'b101, 32'h0000_4003, 32'h0, 0, 0);
    do_load(1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 100, 0);
    do_load(1, 3'b010, 32'h0000_0044, 32'hDEAD_BEEF, 3, 0);
    do_load(1, 3'b000, 32'h0000_0045, 32'h0000_A500, 4, 0);
    sel = 0;
    funct3 = 3'b010;
    addr = 32'h0000_5000;
    start_a = 1;
    step;
    start_a = 0;
    step;
    chk("rst_req1_valid", 32'(mif_a.mem_valid), 1);
    step;
    chk("rst_req2_valid", 32'(mif_a.mem_valid), 1);
    resetn = 0;
    step;
    chk("inflight_rst_valid", 32'(mif_a.mem_valid), 0);
    chk("inflight_rst_busy", 32'(busy_a), 0);
    chk("inflight_rst_addr", mif_a.mem_addr, 0);
    resetn = 1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (done_a) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    do_load(0, 3'b010, 32'h0000_6000, 32'h0BAD_CAFE, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/load_unit.md
# load_unit

Memory read engine for the kianv multicycle rv32im core, the load-side counterpart of the store path. It accepts one load request from the control unit, issues a word-aligned read on the native memory bus, and waits for the ready handshake. It then extracts and sign/zero-extends the byte, halfword or word selected by funct3 and the low address bits. Misaligned and illegal loads are rejected without touching the bus, and a stalled bus is bounded by a timeout.

## Interface
- TIMEOUT, default 255: maximum number of cycles `mem_valid` stays asserted while waiting for `mem_ready`, before the request is aborted; range 1..65535.
- clk  input  1  core clock; all logic is on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request strobe from the control unit; sampled only in IDLE.
- funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011, 110 and 111 are illegal.
- addr  input  32  byte address of the load, sampled with `start`.
- busy  output  1  high from the cycle after an accepted `start` until the cycle `done` is high, inclusive.
- done  output  1  one-cycle completion pulse.
- result  output  32  extended load data; valid while `done` is high and held until the next accepted `start`.
- fault  output  1  valid with `done`: 1 = request aborted because it was misaligned, illegal, or timed out.
- fault_cause  output  2  valid with `done` when `fault` = 1: 01 misaligned, 10 illegal funct3, 11 timeout; 00 when `fault` = 0.
- mem_valid  output  1  read request to the bus.
- mem_addr  output  32  word address, {addr[31:2], 2'b00}.
- mem_ready  input  1  bus acknowledge; `mem_rdata` is valid in the same cycle.
- mem_rdata  input  32  read data, little-endian.

## Operation
- States: IDLE, CHECK, REQ, RESP.
- IDLE: when `start` = 1, latch funct3 and addr and go to CHECK.
- CHECK: decode the latched request.
  - Illegal funct3 goes to RESP with cause 10.
  - LH/LHU with addr[0] = 1 goes to RESP with cause 01.
  - LW with addr[1:0] ≠ 00 goes to RESP with cause 01.
  - Any other request goes to REQ.
- REQ:
  - Drive `mem_valid` = 1 and the word address; clear the timeout counter on entry and increment it each REQ cycle.
  - `mem_ready` = 1: capture the extended data and go to RESP.
  - Counter reaches TIMEOUT without `mem_ready`: go to RESP with cause 11.
- RESP: pulse `done`, present `fault`/`fault_cause`, return to IDLE.
- Extraction:
  - Byte lane = addr[1:0], so lane 0 is bits [7:0] and lane 3 is bits [31:24].
  - Half lane = addr[1], selecting [15:0] or [31:16].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- On a fault, `result` = 0.
- `start` while `busy` = 1 is ignored; there is no queueing.
- `mem_addr` is held stable for the whole REQ interval.

## Timing
- Reset values: `busy` 0, `done` 0, `result` 0, `fault` 0, `fault_cause` 00, `mem_valid` 0, `mem_addr` 0; state IDLE.
- `start` accepted at edge N: CHECK during cycle N+1, with `busy` = 1.
- Legal request: `mem_valid` rises in cycle N+2.
  - If `mem_ready` is high in cycle M (M ≥ N+2), data is captured at the end of M.
  - `mem_valid` = 0 and `done` = 1 in cycle M+1.
  - Minimum latency is `start` to `done` = 3 cycles.
- Misaligned or illegal request: `done` and `fault` in cycle N+2; `mem_valid` is never asserted.
- Timeout: with `mem_valid` first high in cycle N+2 and `mem_ready` held low, `mem_valid` is high for exactly TIMEOUT cycles. `done` with cause 11 follows in the next cycle.
- `mem_ready` arriving in the last allowed cycle counts as success. A `mem_ready` arriving after the abort is ignored.
- `mem_ready` high outside REQ is ignored.
- `resetn` low during any state: at the next edge all outputs take their reset values and any in-flight `mem_valid` drops. No `done` is produced for the aborted request.
- `start` in the same cycle as `done` is ignored, because the block is not in IDLE. The earliest new `start` is accepted in the cycle after `done`.

## Test plan
- LB, addr 0x1003, mem_rdata 0x80FF_0011 with `mem_ready` in the first REQ cycle -> `mem_addr` 0x1000, `result` 0xFFFF_FF80, `fault` 0, `done` 3 cycles after `start`.
- LBU / LHU / LH at addr 0x2002, mem_rdata 0x8765_4321 -> 0x0000_0065, 0x0000_8765 and 0xFFFF_8765 respectively.
- LW, addr 0x3000, `mem_ready` delayed 5 cycles -> `mem_valid` high 6 cycles with a stable address, `result` = mem_rdata, `busy` low after `done`.
- LW at 0x3002 and LH at 0x3001 -> `done`, `fault` 1, cause 01, no `mem_valid` ever; funct3 011 -> cause 10.
- TIMEOUT = 4, `mem_ready` stuck low -> `mem_valid` high exactly 4 cycles, then `done` with cause 11. Repeat with `mem_ready` in the 4th cycle -> success.
- `resetn` low in the 2nd REQ cycle -> `mem_valid` 0 next cycle, no `done`. Extra `start` pulses while busy have no effect.
